zvc_compressor_pipe: RTL and testbench

- Parametrised, multi-cycle successor to the single-line zero-value compressor.
- Accepts one LIFM line and its mapping-table (MT) line through a valid/ready handshake.
- Compacts the non-zero words toward index 0, LANES words per cycle, and carries each word's MT entry with it.
- Returns the packed line, a per-word non-zero mask and a count through a second valid/ready handshake; an optional bypass mode passes lines through uncompressed.

---
 rtl/zvc_compressor_pipe_if.sv | 43 ++++
 rtl/zvc_compressor_pipe.sv | 175 +++++++++++++++++
 tb/tb_zvc_compressor_pipe.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zvc_compressor_pipe_if.sv
`default_nettype none
// =============================================================================
// Module   : zvc_compressor_pipe_if
// Brief    : Line-in / packed-line-out handshake bundle for zvc_compressor_pipe.
// Revision : 1.0 - initial release
// =============================================================================
interface zvc_compressor_pipe_if #(
    parameter int WORD_WIDTH    = 8,
    parameter int LINE_SIZE     = 128,
    parameter int DIST_WIDTH    = 7,
    parameter int MAX_LIFM_RSIZ = 4,
    parameter int CNT_WIDTH     = 8
);
    localparam int MT_WIDTH  = DIST_WIDTH * MAX_LIFM_RSIZ;
    localparam int LINE_BITS = LINE_SIZE * WORD_WIDTH;
    localparam int MT_BITS   = LINE_SIZE * MT_WIDTH;

    logic                 in_valid;
    logic                 in_ready;
    logic                 in_bypass;
    logic [LINE_BITS-1:0] lifm_line;
    logic [MT_BITS-1:0]   mt_line;
    logic                 out_valid;
    logic                 out_ready;
    logic [LINE_BITS-1:0] lifm_comp;
    logic [MT_BITS-1:0]   mt_comp;
    logic [LINE_SIZE-1:0] comp_mask;
    logic [CNT_WIDTH-1:0] comp_cnt;
    logic                 busy;

    // Producer/consumer side of the compressor.
    modport master (
        output in_valid, in_bypass, lifm_line, mt_line, out_ready,
        input  in_ready, out_valid, lifm_comp, mt_comp, comp_mask, comp_cnt, busy
    );

    // The compressor itself.
    modport slave (
        input  in_valid, in_bypass, lifm_line, mt_line, out_ready,
        output in_ready, out_valid, lifm_comp, mt_comp, comp_mask, comp_cnt, busy
    );
endinterface
`default_nettype wire

// File: rtl/zvc_compressor_pipe.sv
`default_nettype none
// =============================================================================
// Module   : zvc_compressor_pipe
// Brief    : Multi-cycle zero-value compressor; packs non-zero LIFM words and
//            their MT entries toward index 0, LANES words per cycle.
// Revision : 1.0 - initial release
// =============================================================================
module zvc_compressor_pipe #(
    parameter int WORD_WIDTH    = 8,
    parameter int LINE_SIZE     = 128,
    parameter int DIST_WIDTH    = 7,
    parameter int MAX_LIFM_RSIZ = 4,
    parameter int LANES         = 16,
    parameter int CNT_WIDTH     = 8
) (
    input  wire logic            clk,
    input  wire logic            reset,
    zvc_compressor_pipe_if.slave bus
);
    localparam int MT_WIDTH  = DIST_WIDTH * MAX_LIFM_RSIZ;
    localparam int LINE_BITS = LINE_SIZE * WORD_WIDTH;
    localparam int MT_BITS   = LINE_SIZE * MT_WIDTH;
    localparam int N_CHUNKS  = LINE_SIZE / LANES;
    localparam int CHUNK_W   = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(N_CHUNKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q,     state_d;
    logic [LINE_BITS-1:0] lifm_in_q,   lifm_in_d;
    logic [MT_BITS-1:0]   mt_in_q,     mt_in_d;
    logic                 bypass_q,    bypass_d;
    logic [LINE_BITS-1:0] lifm_comp_q, lifm_comp_d;
    logic [MT_BITS-1:0]   mt_comp_q,   mt_comp_d;
    logic [LINE_SIZE-1:0] comp_mask_q, comp_mask_d;
    logic [CNT_WIDTH-1:0] wp_q,        wp_d;
    logic [CHUNK_W-1:0]   chunk_q,     chunk_d;

    logic [WORD_WIDTH-1:0] lane_word [LANES];
    logic [MT_WIDTH-1:0]   lane_mt   [LANES];
    logic [CNT_WIDTH-1:0]  lane_slot [LANES];
    logic [LANES-1:0]      lane_keep;
    logic [CNT_WIDTH-1:0]  rank_acc;
    logic [CNT_WIDTH-1:0]  chunk_kept;
    logic                  accept;

    assign bus.in_ready  = (state_q == S_IDLE) && !reset;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.lifm_comp = lifm_comp_q;
    assign bus.mt_comp   = mt_comp_q;
    assign bus.comp_mask = comp_mask_q;
    assign bus.comp_cnt  = wp_q;

    assign accept = bus.in_valid && bus.in_ready;

    // Lane view of the current chunk: word, MT entry, keep flag and the
    // destination slot (write pointer plus prefix rank among kept lanes).
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            lane_word[j] = '0;
            lane_mt[j]   = '0;
        end
        for (int c = 0; c < N_CHUNKS; c++) begin
            if (chunk_q == CHUNK_W'(c)) begin
                for (int j = 0; j < LANES; j++) begin
                    lane_word[j] = lifm_in_q[(c*LANES + j)*WORD_WIDTH +: WORD_WIDTH];
                    lane_mt[j]   = mt_in_q[(c*LANES + j)*MT_WIDTH +: MT_WIDTH];
                end
            end
        end
        rank_acc = '0;
        for (int j = 0; j < LANES; j++) begin
            lane_keep[j] = bypass_q || (lane_word[j] != '0);
            lane_slot[j] = wp_q + rank_acc;
            if (lane_keep[j]) begin
                rank_acc = rank_acc + CNT_WIDTH'(1);
            end
        end
        chunk_kept = rank_acc;
    end

    always_comb begin
        state_d     = state_q;
        lifm_in_d   = lifm_in_q;
        mt_in_d     = mt_in_q;
        bypass_d    = bypass_q;
        lifm_comp_d = lifm_comp_q;
        mt_comp_d   = mt_comp_q;
        comp_mask_d = comp_mask_q;
        wp_d        = wp_q;
        chunk_d     = chunk_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    lifm_in_d   = bus.lifm_line;
                    mt_in_d     = bus.mt_line;
                    bypass_d    = bus.in_bypass;
                    lifm_comp_d = '0;
                    mt_comp_d   = '0;
                    comp_mask_d = '0;
                    wp_d        = '0;
                    chunk_d     = '0;
                    state_d     = S_SCAN;
                end
            end

            S_SCAN: begin
                // Slot-centric scatter: each output slot picks the kept lane
                // whose destination matches it, so no dynamic part-selects.
                for (int s = 0; s < LINE_SIZE; s++) begin
                    for (int j = 0; j < LANES; j++) begin
                        if (lane_keep[j] && (lane_slot[j] == CNT_WIDTH'(s))) begin
                            lifm_comp_d[s*WORD_WIDTH +: WORD_WIDTH] = lane_word[j];
                            mt_comp_d[s*MT_WIDTH +: MT_WIDTH]       = lane_mt[j];
                        end
                    end
                end
                for (int c = 0; c < N_CHUNKS; c++) begin
                    for (int j = 0; j < LANES; j++) begin
                        if ((chunk_q == CHUNK_W'(c)) && lane_keep[j]) begin
                            comp_mask_d[c*LANES + j] = 1'b1;
                        end
                    end
                end
                wp_d = wp_q + chunk_kept;
                if (chunk_q == LAST_CHUNK) begin
                    state_d = S_DONE;
                end else begin
                    chunk_d = chunk_q + CHUNK_W'(1);
                end
            end

            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lifm_in_q   <= '0;
            mt_in_q     <= '0;
            bypass_q    <= 1'b0;
            lifm_comp_q <= '0;
            mt_comp_q   <= '0;
            comp_mask_q <= '0;
            wp_q        <= '0;
            chunk_q     <= '0;
        end else begin
            state_q     <= state_d;
            lifm_in_q   <= lifm_in_d;
            mt_in_q     <= mt_in_d;
            bypass_q    <= bypass_d;
            lifm_comp_q <= lifm_comp_d;
            mt_comp_q   <= mt_comp_d;
            comp_mask_q <= comp_mask_d;
            wp_q        <= wp_d;
            chunk_q     <= chunk_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_zvc_compressor_pipe.sv
`default_nettype none
// =============================================================================
// Module   : tb_zvc_compressor_pipe
// Brief    : Directed plus random-line bench for zvc_compressor_pipe against
//            an ordered-filter reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_zvc_compressor_pipe;
    localparam int W   = 8;
    localparam int LS  = 128;
    localparam int DW  = 7;
    localparam int RS  = 4;
    localparam int LN  = 16;
    localparam int CW  = 8;
    localparam int MTW = DW * RS;
    localparam int LW  = LS * W;
    localparam int MW  = LS * MTW;
    localparam int VW  = 4096;
    localparam int N   = LS / LN;

    logic clk;
    logic reset;

    zvc_compressor_pipe_if #(
        .WORD_WIDTH(W), .LINE_SIZE(LS), .DIST_WIDTH(DW),
        .MAX_LIFM_RSIZ(RS), .CNT_WIDTH(CW)
    ) bus_if ();

    zvc_compressor_pipe #(
        .WORD_WIDTH(W), .LINE_SIZE(LS), .DIST_WIDTH(DW),
        .MAX_LIFM_RSIZ(RS), .LANES(LN), .CNT_WIDTH(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [LW-1:0] e_lifm;
    logic [MW-1:0] e_mt;
    logic [LS-1:0] e_mask;
    int            e_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [VW-1:0] obs,
                           input logic [VW-1:0] exp, input int ew);
        logic [VW-1:0] d;
        logic [63:0]   msk;
        logic [63:0]   eo;
        logic [63:0]   ee;
        int            idx;
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            msk = (64'd1 << ew) - 64'd1;
            d   = obs ^ exp;
            idx = 0;
            while ((idx * ew < VW) && ((64'(d >> (idx * ew)) & msk) == 64'd0)) idx++;
            eo = 64'(obs >> (idx * ew)) & msk;
            ee = 64'(exp >> (idx * ew)) & msk;
            $error("FAIL %s: element %0d observed %0h expected %0h", tag, idx, eo, ee);
        end
    endtask

    // Reference: keep words in original order, dropping zeros unless bypassed.
    task automatic model(input logic [LW-1:0] li, input logic [MW-1:0] mi, input logic byp);
        int k;
        k      = 0;
        e_lifm = '0;
        e_mt   = '0;
        e_mask = '0;
        for (int i = 0; i < LS; i++) begin
            if (byp || (li[i*W +: W] != '0)) begin
                e_lifm[k*W +: W]     = li[i*W +: W];
                e_mt[k*MTW +: MTW]   = mi[i*MTW +: MTW];
                e_mask[i]            = 1'b1;
                k++;
            end
        end
        e_cnt = k;
    endtask

    task automatic gen(input int dens, output logic [LW-1:0] li, output logic [MW-1:0] mi);
        for (int i = 0; i < LS; i++) begin
            li[i*W +: W]     = ($urandom_range(0, 99) < dens) ? W'($urandom_range(1, 255)) : '0;
            mi[i*MTW +: MTW] = MTW'($urandom);
        end
    endtask

    task automatic accept_line(input logic [LW-1:0] li, input logic [MW-1:0] mi,
                               input logic byp, input string tag);
        int cyc;
        cyc = 0;
        bus_if.lifm_line = li;
        bus_if.mt_line   = mi;
        bus_if.in_bypass = byp;
        bus_if.in_valid  = 1'b1;
        while (bus_if.in_ready !== 1'b1 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "/in_ready_before_accept"}, 64'(bus_if.in_ready), 64'd1);
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        chk({tag, "/scan_in_ready"}, 64'(bus_if.in_ready), 64'd0);
        chk({tag, "/scan_busy"}, 64'(bus_if.busy), 64'd1);
    endtask

    task automatic wait_result(input string tag);
        int lat;
        lat = 0;
        while (bus_if.out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "/latency"}, 64'(lat), 64'(N));
        chk_vec({tag, "/lifm_comp"}, VW'(bus_if.lifm_comp), VW'(e_lifm), W);
        chk_vec({tag, "/mt_comp"}, VW'(bus_if.mt_comp), VW'(e_mt), MTW);
        chk_vec({tag, "/comp_mask"}, VW'(bus_if.comp_mask), VW'(e_mask), 1);
        chk({tag, "/comp_cnt"}, 64'(bus_if.comp_cnt), 64'(e_cnt));
        chk({tag, "/done_in_ready"}, 64'(bus_if.in_ready), 64'd0);
    endtask

    task automatic release_result(input string tag);
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
        chk({tag, "/release_out_valid"}, 64'(bus_if.out_valid), 64'd0);
        chk({tag, "/release_in_ready"}, 64'(bus_if.in_ready), 64'd1);
    endtask

    task automatic run_line(input logic [LW-1:0] li, input logic [MW-1:0] mi,
                            input logic byp, input string tag);
        model(li, mi, byp);
        accept_line(li, mi, byp, tag);
        wait_result(tag);
        release_result(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] l;
        logic [MW-1:0] m;
        logic [LW-1:0] l2;
        logic [MW-1:0] m2;
        logic [LW-1:0] snap_lifm;
        logic [CW-1:0] snap_cnt;
        int            ov_seen;

        reset            = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.in_bypass = 1'b0;
        bus_if.lifm_line = '0;
        bus_if.mt_line   = '0;
        bus_if.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset/in_ready", 64'(bus_if.in_ready), 64'd0);
        chk("reset/out_valid", 64'(bus_if.out_valid), 64'd0);
        chk("reset/busy", 64'(bus_if.busy), 64'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        chk("idle/in_ready", 64'(bus_if.in_ready), 64'd1);
        chk("idle/comp_cnt", 64'(bus_if.comp_cnt), 64'd0);
        chk_vec("idle/lifm_comp", VW'(bus_if.lifm_comp), '0, W);

        // out_ready with nothing pending does nothing.
        bus_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        chk("idle_out_ready/out_valid", 64'(bus_if.out_valid), 64'd0);
        chk("idle_out_ready/busy", 64'(bus_if.busy), 64'd0);

        // Three sparse words inside one chunk.
        l = '0; m = '0;
        l[3*W +: W] = 8'd13; l[8*W +: W] = 8'd47; l[15*W +: W] = 8'd22;
        m[3*MTW +: MTW] = 28'd1; m[8*MTW +: MTW] = 28'd1; m[15*MTW +: MTW] = 28'd1;
        model(l, m, 1'b0);
        accept_line(l, m, 1'b0, "sparse");
        wait_result("sparse");
        chk("sparse/word0", 64'(bus_if.lifm_comp[0 +: W]), 64'd13);
        chk("sparse/word1", 64'(bus_if.lifm_comp[W +: W]), 64'd47);
        chk("sparse/word2", 64'(bus_if.lifm_comp[2*W +: W]), 64'd22);
        chk("sparse/cnt_const", 64'(bus_if.comp_cnt), 64'd3);
        release_result("sparse");

        // Words spread across chunks.
        l = '0; m = '0;
        l[5*W +: W] = 8'd15; l[32*W +: W] = 8'd74; l[75*W +: W] = 8'd35;
        m[5*MTW +: MTW] = 28'd1; m[32*MTW +: MTW] = 28'd1; m[75*MTW +: MTW] = 28'd1;
        run_line(l, m, 1'b0, "cross_chunk");

        // Every word non-zero.
        for (int i = 0; i < LS; i++) begin
            l[i*W +: W]     = W'(i + 1);
            m[i*MTW +: MTW] = MTW'($urandom);
        end
        run_line(l, m, 1'b0, "all_nonzero");

        // All-zero line with junk MT entries.
        l = '0;
        run_line(l, m, 1'b0, "all_zero");

        // Bypass keeps zeros in place.
        l = '0; m = '0;
        l[3*W +: W] = 8'd13;
        m[3*MTW +: MTW] = 28'd1;
        run_line(l, m, 1'b1, "bypass");

        // Backpressure: result held while a new line waits.
        gen(40, l, m);
        gen(25, l2, m2);
        model(l, m, 1'b0);
        accept_line(l, m, 1'b0, "bp_a");
        wait_result("bp_a");
        snap_lifm = bus_if.lifm_comp;
        snap_cnt  = bus_if.comp_cnt;
        bus_if.lifm_line = l2;
        bus_if.mt_line   = m2;
        bus_if.in_bypass = 1'b0;
        bus_if.in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp/out_valid_held", 64'(bus_if.out_valid), 64'd1);
            chk("bp/in_ready_low", 64'(bus_if.in_ready), 64'd0);
            chk_vec("bp/lifm_stable", VW'(bus_if.lifm_comp), VW'(snap_lifm), W);
            chk("bp/cnt_stable", 64'(bus_if.comp_cnt), 64'(snap_cnt));
        end
        release_result("bp_a");
        model(l2, m2, 1'b0);
        accept_line(l2, m2, 1'b0, "bp_b");
        wait_result("bp_b");
        release_result("bp_b");

        // Reset on the third scan cycle aborts the line.
        gen(60, l, m);
        accept_line(l, m, 1'b0, "abort");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("abort/in_ready_in_reset", 64'(bus_if.in_ready), 64'd0);
        chk("abort/busy_in_reset", 64'(bus_if.busy), 64'd0);
        chk("abort/out_valid_in_reset", 64'(bus_if.out_valid), 64'd0);
        chk("abort/cnt_cleared", 64'(bus_if.comp_cnt), 64'd0);
        chk_vec("abort/lifm_cleared", VW'(bus_if.lifm_comp), '0, W);
        chk_vec("abort/mt_cleared", VW'(bus_if.mt_comp), '0, MTW);
        chk_vec("abort/mask_cleared", VW'(bus_if.comp_mask), '0, 1);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        chk("abort/in_ready_after", 64'(bus_if.in_ready), 64'd1);
        ov_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (bus_if.out_valid === 1'b1) ov_seen++;
        end
        chk("abort/never_emitted", 64'(ov_seen), 64'd0);
        gen(50, l, m);
        run_line(l, m, 1'b0, "after_abort");

        // Random lines, random density and bypass.
        for (int t = 0; t < 6; t++) begin
            gen(int'($urandom_range(0, 100)), l, m);
            run_line(l, m, ($urandom_range(0, 3) == 0), $sformatf("rand%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
